// File: rtl/main_mem_bridge.sv
// main_mem_bridge: serialises cache block reads and write-through stores onto a 32-bit word bus
module main_mem_bridge #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  main_mem_addr,
  input  logic [31:0]  main_mem_data_out,
  input  logic         main_mem_read_req,
  input  logic         main_mem_write_req,
  output logic [511:0] main_mem_data_in,
  output logic         main_mem_ready,
  output logic         bus_req,
  output logic         bus_we,
  output logic [31:0]  bus_addr,
  output logic [31:0]  bus_wdata,
  input  logic         bus_ack,
  input  logic [31:0]  bus_rdata,
  output logic         busy,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] k_q, k_d;
  logic [15:0] wait_q, wait_d;
  logic [511:0] data_q, data_d;
  logic err_q, err_d, ready_q, ready_d, busy_q, busy_d;
  assign bus_req = state_q == READ || state_q == WRITE;
  assign bus_we = state_q == WRITE;
  assign bus_addr = addr_q + {26'd0, k_q, 2'b00};
  assign bus_wdata = wdata_q;
  assign main_mem_data_in = data_q;
  assign main_mem_ready = ready_q;
  assign busy = busy_q;
  assign err = err_q;
  // request capture, beat sequencing, line assembly and per-beat watchdog
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    k_d = k_q;
    wait_d = wait_q;
    data_d = data_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (main_mem_read_req || main_mem_write_req) begin
          addr_d = main_mem_addr & (main_mem_read_req ? 32'hFFFF_FFC0 : 32'hFFFF_FFFC);
          err_d = 1'b0;
          k_d = 4'd0;
          wait_d = 16'd0;
          state_d = main_mem_read_req ? READ : WRITE;
          if (main_mem_read_req) data_d = '0;
          else wdata_d = main_mem_data_out;
        end
      end
      READ, WRITE: begin
        if (bus_ack) begin
          wait_d = 16'd0;
          if (state_q == READ) begin
            data_d[{k_q, 5'd0} +: 32] = bus_rdata;
            k_d = k_q + 4'd1;
            if (k_q == 4'd15) state_d = RESP;
          end else state_d = RESP;
        end else if (wait_q == WAIT_LIM) begin
          wait_d = 16'd0;
          err_d = 1'b1;
          state_d = RESP;
        end else wait_d = wait_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == RESP;
    busy_d = state_d != IDLE;
  end
  // state and registered outputs; reset discards any partial transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      k_q <= '0;
      wait_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      k_q <= k_d;
      wait_q <= wait_d;
      data_q <= data_d;
      err_q <= err_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_main_mem_bridge.sv
// tb_main_mem_bridge: table-driven scoreboard bench with a configurable bus responder
module tb_main_mem_bridge;
  localparam int TO = 4;
  localparam logic [31:0] PAT = 32'hA000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] main_mem_addr = '0, main_mem_data_out = '0, bus_rdata = '0;
  logic main_mem_read_req = 1'b0, main_mem_write_req = 1'b0, bus_ack = 1'b0;
  logic [511:0] main_mem_data_in;
  logic main_mem_ready, bus_req, bus_we, busy, err;
  logic [31:0] bus_addr, bus_wdata;
  main_mem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .main_mem_addr(main_mem_addr), .main_mem_data_out(main_mem_data_out),
    .main_mem_read_req(main_mem_read_req), .main_mem_write_req(main_mem_write_req),
    .main_mem_data_in(main_mem_data_in), .main_mem_ready(main_mem_ready), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rd, wr, poke;
    logic [31:0] addr, wdata;
    int waits, acks, lat;
    logic err;
  } vec_t;
  typedef struct { logic [511:0] data; logic err; } resp_t;
  typedef struct { logic we; logic [31:0] addr, wdata; } beat_t;
  resp_t sb[$];
  beat_t bq[$];
  beat_t cur_beat;
  int total = 0, bad = 0;
  int waits = 0, acks_left = 0, wcnt = 0;
  logic [511:0] last_data = '0;
  vec_t tbl[9];
  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // bus responder: ack after 'waits' idle cycles, up to 'acks_left' beats, checking each beat
  initial forever begin
    @(negedge clk);
    bus_ack = 1'b0;
    if (rst_n && bus_req) begin
      if (wcnt >= waits && acks_left > 0) begin
        bus_ack = 1'b1;
        bus_rdata = PAT + {28'd0, bus_addr[5:2]};
        acks_left--;
        wcnt = 0;
        if (bq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %0h we %0b want no beat", bus_addr, bus_we);
        end else begin
          cur_beat = bq.pop_front();
          chk("beat_we", 512'(bus_we), 512'(cur_beat.we));
          chk("beat_addr", 512'(bus_addr), 512'(cur_beat.addr));
          if (cur_beat.we) chk("beat_wdata", 512'(bus_wdata), 512'(cur_beat.wdata));
        end
      end else wcnt++;
    end else wcnt = 0;
  end
  task automatic run(vec_t v);
    resp_t r;
    int n, rc;
    logic [31:0] base;
    base = {v.addr[31:6], 6'd0};
    r.data = last_data;
    r.err = v.err;
    if (v.rd) begin
      r.data = '0;
      for (int k = 0; k < 16; k++)
        if (k < v.acks) begin
          r.data[k*32 +: 32] = PAT + 32'(k);
          bq.push_back('{1'b0, base + 32'(k * 4), 32'd0});
        end
      last_data = r.data;
    end else if (v.acks > 0) bq.push_back('{1'b1, {v.addr[31:2], 2'b00}, v.wdata});
    sb.push_back(r);
    @(negedge clk);
    waits = v.waits;
    acks_left = v.acks;
    main_mem_read_req = v.rd;
    main_mem_write_req = v.wr;
    main_mem_addr = v.addr;
    main_mem_data_out = v.wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        main_mem_read_req = 1'b0;
        main_mem_write_req = 1'b0;
        main_mem_addr = 32'hFFFF_FFFF;
        main_mem_data_out = 32'h0BAD_0BAD;
        chk("busy_after_req", 512'(busy), 512'(1));
        chk("err_cleared_on_req", 512'(err), 512'(0));
      end
      if (v.poke && n == 5) begin
        main_mem_read_req = 1'b1;
        main_mem_write_req = 1'b1;
        main_mem_addr = 32'h0000_9000;
      end
      if (v.poke && n == 6) begin
        main_mem_read_req = 1'b0;
        main_mem_write_req = 1'b0;
      end
    end while (!main_mem_ready && n < 200);
    chk("latency", 512'(n), 512'(v.lat));
    r = sb.pop_front();
    chk("line_data", main_mem_data_in, r.data);
    chk("err_at_ready", 512'(err), 512'(r.err));
    chk("bus_req_at_ready", 512'(bus_req), 512'(0));
    rc = 0;
    repeat (5) begin
      @(negedge clk);
      rc += int'(main_mem_ready);
    end
    chk("no_extra_ready", 512'(rc), 512'(0));
    chk("busy_idle", 512'(busy), 512'(0));
    chk("beats_consumed", 512'(bq.size()), 512'(0));
    bq.delete();
  endtask
  initial begin
    int rc;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, 16, 17, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 2, 16, 49, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2006, 32'hDEAD_BEEF, 0, 1, 2, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, 3, 8, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h1234_5678, 0, 0, 5, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_2008, 32'hCAFE_F00D, 1, 1, 3, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 1, 16, 33, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h5555_AAAA, 0, 16, 17, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 0, 16, 17, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_ready", 512'(main_mem_ready), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    chk("rst_bus_req", 512'(bus_req), 512'(0));
    chk("rst_bus_we", 512'(bus_we), 512'(0));
    chk("rst_bus_addr", 512'(bus_addr), 512'(0));
    chk("rst_bus_wdata", 512'(bus_wdata), 512'(0));
    chk("rst_data", main_mem_data_in, 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tbl[i]) run(tbl[i]);
    for (int k = 0; k < 7; k++) bq.push_back('{1'b0, 32'h0000_1200 + 32'(k * 4), 32'd0});
    @(negedge clk);
    waits = 0;
    acks_left = 7;
    main_mem_read_req = 1'b1;
    main_mem_addr = 32'h0000_1234;
    @(negedge clk);
    main_mem_read_req = 1'b0;
    repeat (7) @(negedge clk);
    chk("partial_word0", 512'(main_mem_data_in[31:0]), 512'(PAT));
    chk("stalled_bus_req", 512'(bus_req), 512'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", 512'(bus_req), 512'(0));
    chk("mid_rst_data", main_mem_data_in, 512'(0));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_ready", 512'(main_mem_ready), 512'(0));
    chk("mid_rst_beats", 512'(bq.size()), 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc = 0;
    repeat (25) begin
      @(negedge clk);
      rc += int'(main_mem_ready);
    end
    chk("no_ready_after_rst", 512'(rc), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
